// File: rtl/cache_pkg.sv
// cache_pkg: shared types, default geometry and address-field helpers for the data cache.
//   CacheStateT : controller state (IDLE, REFILL, WRITE).
//   f_word/f_index/f_tag : split a 32-bit byte address into word, index and tag fields.
package cache_pkg;
  typedef enum logic [1:0] {IDLE, REFILL, WRITE} CacheStateT;
  localparam int DEF_LINES  = 64;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int OFF_W      = 2;
  function automatic logic [31:0] f_word(input logic [31:0] a, input int ww);
    return (a >> OFF_W) & ((32'd1 << ww) - 32'd1);
  endfunction
  function automatic logic [31:0] f_index(input logic [31:0] a, input int ww, input int iw);
    return (a >> (OFF_W + ww)) & ((32'd1 << iw) - 32'd1);
  endfunction
  function automatic logic [31:0] f_tag(input logic [31:0] a, input int ww, input int iw);
    return a >> (OFF_W + ww + iw);
  endfunction
endpackage

// File: rtl/cache_line_store.sv
// cache_line_store: valid/tag/data arrays of the direct-mapped cache.
//   rd_*  : combinational lookup of one line (valid, tag) and one word of it.
//   wr_*  : byte-enabled write of one word.
//   set_valid/set_tag : mark line wr_index valid with a new tag.
//   iRst  : asynchronously clears the valid bits only.
module cache_line_store #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 24
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic [$clog2(LINES)-1:0]          rd_index,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] rd_word,
  output logic                              rd_valid,
  output logic [TAG_W-1:0]                  rd_tag,
  output logic [31:0]                       rd_data,
  input  logic                              wr_en,
  input  logic [$clog2(LINES)-1:0]          wr_index,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] wr_word,
  input  logic [31:0]                       wr_data,
  input  logic [3:0]                        wr_be,
  input  logic                              set_valid,
  input  logic [TAG_W-1:0]                  set_tag
);
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [31:0]      data_q [LINES*WORDS_PER_LINE];
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) valid_q <= '0;
    else if (set_valid) valid_q[wr_index] <= 1'b1;
  end
  always_ff @(posedge iClk) begin
    if (set_valid) tag_q[wr_index] <= set_tag;
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) data_q[{wr_index, wr_word}][8*b +: 8] <= wr_data[8*b +: 8];
  end
  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[{rd_index, rd_word}];
endmodule

// File: rtl/data_cache_m.sv
// data_cache_m: direct-mapped, write-through, no-write-allocate memory-stage data cache.
//   iReadEn/iWriteEn/iAddress/iWriteData/iByteEn : memory-stage access.
//   oReadData/oStall : load result (same-cycle on hit) and pipeline freeze request.
//   oMem*/iMem*      : single-outstanding backing-memory port (request/ready, in-order read return).
module data_cache_m
  import cache_pkg::*;
#(
  parameter int LINES          = DEF_LINES,
  parameter int WORDS_PER_LINE = DEF_WORDS,
  parameter int ADDR_W         = DEF_ADDR_W
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReadEn,
  input  logic              iWriteEn,
  input  logic [ADDR_W-1:0] iAddress,
  input  logic [31:0]       iWriteData,
  input  logic [3:0]        iByteEn,
  output logic [31:0]       oReadData,
  output logic              oStall,
  output logic              oMemReq,
  output logic              oMemWe,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [31:0]       oMemWData,
  output logic [3:0]        oMemBe,
  input  logic              iMemReady,
  input  logic              iMemRValid,
  input  logic [31:0]       iMemRData
);
  localparam int WW = $clog2(WORDS_PER_LINE);
  localparam int IW = $clog2(LINES);
  localparam int TW = ADDR_W - OFF_W - WW - IW;
  CacheStateT        state_q, state_d;
  logic [WW-1:0]     cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [WW-1:0]     in_word;
  logic [IW-1:0]     in_index, ref_index;
  logic [TW-1:0]     in_tag, ref_tag, line_tag;
  logic              line_valid, hit, refill_beat, store_hit, last_beat;
  logic [31:0]       line_data;
  assign in_word   = WW'(f_word(32'(iAddress), WW));
  assign in_index  = IW'(f_index(32'(iAddress), WW, IW));
  assign in_tag    = TW'(f_tag(32'(iAddress), WW, IW));
  assign ref_index = IW'(f_index(32'(addr_q), WW, IW));
  assign ref_tag   = TW'(f_tag(32'(addr_q), WW, IW));
  assign hit         = line_valid && line_tag == in_tag;
  // a beat only counts while a read is accepted and outstanding, so stray returns are dropped
  assign refill_beat = state_q == REFILL && pend_q && iMemRValid;
  assign last_beat   = refill_beat && cnt_q == WW'(WORDS_PER_LINE - 1);
  assign store_hit   = state_q == IDLE && iWriteEn && hit;
  cache_line_store #(.LINES(LINES), .WORDS_PER_LINE(WORDS_PER_LINE), .TAG_W(TW)) u_store (
    .iClk      (iClk),
    .iRst      (iRst),
    .rd_index  (in_index),
    .rd_word   (in_word),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .wr_en     (store_hit || refill_beat),
    .wr_index  (refill_beat ? ref_index : in_index),
    .wr_word   (refill_beat ? cnt_q : in_word),
    .wr_data   (refill_beat ? iMemRData : iWriteData),
    .wr_be     (refill_beat ? 4'hF : iByteEn),
    .set_valid (last_beat),
    .set_tag   (ref_tag)
  );
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    case (state_q)
      IDLE:
        if (iWriteEn) begin
          state_d = WRITE;
          addr_d  = {iAddress[ADDR_W-1:OFF_W], 2'b00};
          wdata_d = iWriteData;
          be_d    = iByteEn;
        end else if (iReadEn && !hit) begin
          state_d = REFILL;
          cnt_d   = '0;
          pend_d  = 1'b0;
          addr_d  = {iAddress[ADDR_W-1:OFF_W+WW], {(OFF_W+WW){1'b0}}};
        end
      REFILL:
        if (!pend_q && iMemReady) pend_d = 1'b1;
        else if (refill_beat) begin
          pend_d  = 1'b0;
          cnt_d   = cnt_q + 1'b1;
          addr_d  = addr_q + ADDR_W'(4);
          state_d = last_beat ? IDLE : REFILL;
        end
      WRITE:
        state_d = iMemReady ? IDLE : WRITE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    oMemReq   = (state_q == REFILL && !pend_q) || state_q == WRITE;
    oMemWe    = state_q == WRITE;
    oMemAddr  = addr_q;
    oMemWData = wdata_q;
    oMemBe    = be_q;
    // the write retires in its acceptance cycle, so the stall drops with iMemReady
    oStall    = !iRst && (state_q == REFILL || (state_q == WRITE && !iMemReady) ||
                (state_q == IDLE && (iWriteEn || (iReadEn && !hit))));
    oReadData = (!iRst && state_q == IDLE && iReadEn && hit) ? line_data : 32'd0;
  end
endmodule

// File: tb/tb_data_cache_m.sv
// tb_data_cache_m: directed self-checking bench for data_cache_m with a simple backing-memory model.
module tb_data_cache_m;
  logic        iClk = 0, iRst = 1, iReadEn = 0, iWriteEn = 0;
  logic [31:0] iAddress = 0, iWriteData = 0;
  logic [3:0]  iByteEn = 0;
  logic        iMemReady = 1, iMemRValid = 0;
  logic [31:0] iMemRData = 0;
  logic [31:0] oReadData, oMemAddr, oMemWData;
  logic        oStall, oMemReq, oMemWe;
  logic [3:0]  oMemBe;
  int passed = 0, total = 0;
  int n_rd = 0, n_wr = 0, stray_req = 0, stray_done = 0;
  logic        rv_pend = 0;
  logic [31:0] rv_addr = 0, last_waddr = 0, cur;
  logic [3:0]  last_wbe = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_log [$];

  data_cache_m dut (
    .iClk(iClk), .iRst(iRst), .iReadEn(iReadEn), .iWriteEn(iWriteEn), .iAddress(iAddress),
    .iWriteData(iWriteData), .iByteEn(iByteEn), .oReadData(oReadData), .oStall(oStall),
    .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr), .oMemWData(oMemWData),
    .oMemBe(oMemBe), .iMemReady(iMemReady), .iMemRValid(iMemRValid), .iMemRData(iMemRData)
  );

  always #5 iClk = ~iClk;

  // backing memory: samples the request late in each cycle, returns read data one cycle after acceptance
  initial begin
    mem[32'h100] = 32'hDEADBEEF; mem[32'h104] = 32'h11223344;
    mem[32'h108] = 32'h55AA55AA; mem[32'h10C] = 32'h0F0F0F0F;
    mem[32'h500] = 32'hCAFEF00D; mem[32'h504] = 32'h00000504;
    mem[32'h508] = 32'h00000508; mem[32'h50C] = 32'h0000050C;
    mem[32'h300] = 32'hA5A50300; mem[32'h304] = 32'hA5A50304;
    mem[32'h308] = 32'hA5A50308; mem[32'h30C] = 32'hA5A5030C;
    forever begin
      @(negedge iClk); #2;
      iMemRValid = 0;
      if (rv_pend) begin
        iMemRValid = 1;
        iMemRData  = mem.exists(rv_addr) ? mem[rv_addr] : 32'h0;
        rv_pend    = 0;
      end else if (stray_req != stray_done) begin
        stray_done = stray_req;
        iMemRValid = 1;
        iMemRData  = 32'hBAD0BAD0;
      end
      if (!iRst && oMemReq && iMemReady) begin
        if (oMemWe) begin
          n_wr++;
          last_waddr = oMemAddr;
          last_wbe   = oMemBe;
          cur = mem.exists(oMemAddr) ? mem[oMemAddr] : 32'h0;
          for (int b = 0; b < 4; b++) if (oMemBe[b]) cur[8*b +: 8] = oMemWData[8*b +: 8];
          mem[oMemAddr] = cur;
        end else begin
          n_rd++;
          rv_pend = 1;
          rv_addr = oMemAddr;
          rd_log.push_back(oMemAddr);
        end
      end
    end
  end

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", t, got, exp);
  endtask

  task automatic chk_reset_outputs(input string t);
    chk({t, "_stall"}, 32'(oStall), 0);
    chk({t, "_req"}, 32'(oMemReq), 0);
    chk({t, "_we"}, 32'(oMemWe), 0);
    chk({t, "_addr"}, oMemAddr, 0);
    chk({t, "_wdata"}, oMemWData, 0);
    chk({t, "_be"}, 32'(oMemBe), 0);
    chk({t, "_rdata"}, oReadData, 0);
  endtask

  task automatic do_reset(input string t);
    @(negedge iClk); iRst = 1; #1;
    chk_reset_outputs(t);
    @(negedge iClk); iRst = 0;
  endtask

  task automatic do_load(input string t, input logic [31:0] a, input logic [31:0] exp, input int reads);
    int n0;
    n0 = n_rd;
    @(negedge iClk); iReadEn = 1; iAddress = a; #1;
    chk({t, "_stall_first"}, 32'(oStall), (reads != 0) ? 32'd1 : 32'd0);
    if (reads == 0) chk({t, "_no_req"}, 32'(oMemReq), 0);
    for (int k = 0; k < 100 && oStall; k++) begin @(negedge iClk); #1; end
    chk({t, "_stall_end"}, 32'(oStall), 0);
    chk({t, "_data"}, oReadData, exp);
    #2;
    chk({t, "_reads"}, 32'(n_rd - n0), 32'(reads));
    @(negedge iClk); iReadEn = 0;
  endtask

  task automatic do_store(input string t, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    int w0, r0;
    w0 = n_wr; r0 = n_rd;
    @(negedge iClk); iWriteEn = 1; iAddress = a; iWriteData = d; iByteEn = be; #1;
    chk({t, "_stall_first"}, 32'(oStall), 1);
    for (int k = 0; k < 100 && oStall; k++) begin @(negedge iClk); #1; end
    chk({t, "_stall_end"}, 32'(oStall), 0);
    chk({t, "_we"}, 32'(oMemWe), 1);
    #2;
    chk({t, "_writes"}, 32'(n_wr - w0), 1);
    chk({t, "_waddr"}, last_waddr, a);
    chk({t, "_wbe"}, 32'(last_wbe), 32'(be));
    chk({t, "_no_reads"}, 32'(n_rd - r0), 0);
    @(negedge iClk); iWriteEn = 0;
  endtask

  initial begin
    int n0;
    repeat (2) @(negedge iClk);
    #1;
    chk_reset_outputs("reset");
    @(negedge iClk); iRst = 0;
    // cold miss, refill order, then same-cycle hit
    do_load("s1_miss", 32'h100, 32'hDEADBEEF, 4);
    for (int i = 0; i < 4; i++) chk("s1_refill_addr", rd_log[i], 32'h100 + 32'(4 * i));
    do_load("s1_hit", 32'h100, 32'hDEADBEEF, 0);
    // store hit merges bytes into the cached word
    do_store("s2", 32'h104, 32'h000000AA, 4'b0001);
    do_load("s2_hit", 32'h104, 32'h112233AA, 0);
    // store miss does not allocate
    do_store("s3", 32'h2000, 32'h55667788, 4'hF);
    do_load("s3_miss", 32'h2000, 32'h55667788, 4);
    // cold cache, then conflict eviction on index 16
    do_reset("mid_reset");
    do_load("s4_a", 32'h100, 32'hDEADBEEF, 4);
    do_load("s4_b", 32'h500, 32'hCAFEF00D, 4);
    do_load("s4_c", 32'h100, 32'hDEADBEEF, 4);
    do_load("unaligned", 32'h102, 32'hDEADBEEF, 0);
    // back-pressure on a store that hits
    @(negedge iClk);
    iMemReady = 0; iWriteEn = 1; iAddress = 32'h108; iWriteData = 32'h12345678; iByteEn = 4'b1100; #1;
    chk("s5_stall_first", 32'(oStall), 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge iClk); #1;
      chk("s5_stall", 32'(oStall), 1);
      chk("s5_req", 32'(oMemReq), 1);
      chk("s5_addr", oMemAddr, 32'h108);
      chk("s5_wdata", oMemWData, 32'h12345678);
      chk("s5_be", 32'(oMemBe), 32'hC);
    end
    @(negedge iClk); iMemReady = 1; #1;
    chk("s5_release", 32'(oStall), 0);
    @(negedge iClk); iWriteEn = 0;
    do_load("s5_hit", 32'h108, 32'h123455AA, 0);
    // reset after two refill words; stray returns must be ignored
    n0 = n_rd;
    @(negedge iClk); iReadEn = 1; iAddress = 32'h300;
    for (int k = 0; k < 100 && n_rd - n0 < 3; k++) begin @(negedge iClk); #3; end
    chk("s6_progress", 32'(n_rd - n0), 3);
    iRst = 1; #1;
    chk_reset_outputs("s6_reset");
    @(negedge iClk); iRst = 0; iReadEn = 0; stray_req++;
    do_load("s6_reload", 32'h300, 32'hA5A50300, 4);
    for (int i = 0; i < 4; i++) chk("s6_refill_addr", rd_log[rd_log.size() - 4 + i], 32'h300 + 32'(4 * i));
    do_load("s6_hit", 32'h30C, 32'hA5A5030C, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
